pmpcsrctrl: RTL and testbench
=============================

# pmpcsrctrl

Configuration controller for the physical memory protection checker. It owns the `pmpcfg`/`pmpaddr` CSR state, legalizes and lock-filters CSR writes, and drives the per-entry config and address arrays that the checker consumes every cycle. It also serves CSR reads and emits a one-cycle change pulse so that downstream fetch/LSU logic can discard stale permission results. It sits in the privileged CSR unit, alongside the machine-mode CSR file.

## Interface
- `PMP_ENTRIES`, 16, number of implemented entries: 0, 16 or 64.
- `PA_BITS`, 56, physical address width.
- `XLEN`, 64, 32 or 64.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `CSRMWriteM`  in  1  machine CSR write strobe, already gated by stall/flush.
- `CSRAdrM`  in  12  CSR address.
- `CSRWriteValM`  in  XLEN  write data.
- `CSRReadValM`  out  XLEN  read data for `CSRAdrM`; combinational.
- `IllegalPMPAccessM`  out  1  `CSRAdrM` is `pmpcfg` odd-numbered on XLEN=64; combinational.
- `PMPCFG_ARRAY_REGW`  out  [PMP_ENTRIES][8]  per-entry config byte.
- `PMPADDR_ARRAY_REGW`  out  [PMP_ENTRIES][PA_BITS-2]  per-entry address.
- `PMPChangedM`  out  1  registered pulse after any stored bit changes.

## Operation
- **Address map**
  - `pmpcfgN` is at 0x3A0+N, N=0..15.
  - `pmpaddrI` is at 0x3B0+I, I=0..63.
  - Config byte b of `pmpcfgN` maps to entry 4N+b. On XLEN=64, `pmpcfgN` (N even) carries bytes 0..7.
- **Config byte legalization**, per written byte, when the entry is not locked:
  - Bits 6:5 are stored as 0.
  - If W=1 and R=0, W is stored as 0.
  - All four A encodings are legal; granularity is 0.
- **Lock filtering**
  - A config byte write is ignored if the stored L=1.
  - A `pmpaddrI` write is ignored if cfg[I].L=1, or if cfg[I+1].L=1 and cfg[I+1].A=TOR.
  - Lock checks use pre-write state. This includes a `pmpcfg` write that sets L in the same CSR word as other bytes: each byte is filtered by its own old L only.
- **Address writes**
  - `pmpaddr` stores bits [PA_BITS-3:0] of the write data; upper bits are dropped.
  - Reads zero-extend the stored value.
- **Unimplemented entries** (index ≥ PMP_ENTRIES): read 0, writes are dropped, no illegal flag.
- **Odd `pmpcfg` on XLEN=64**: `IllegalPMPAccessM`=1, the write is dropped, and the read returns 0.
- **Non-PMP addresses**: `CSRReadValM`=0, no state change, no illegal flag.
- **Change pulse**: `PMPChangedM` is set for exactly one cycle following a write that altered at least one stored bit. A write fully blocked by lock, or writing identical data, produces no pulse. Back-to-back changing writes hold it high for consecutive cycles.

## Timing
- Writes commit at the rising edge where `CSRMWriteM`=1; the arrays update the same edge.
- The checker sees the new value in the cycle after the write.
- A same-cycle read of the register being written returns the old value.
- Reset (synchronous, any cycle, including one where `CSRMWriteM`=1):
  - All config bytes = 0 (A=OFF, L=0).
  - All addresses = 0.
  - `PMPChangedM`=0.
  - A write coincident with reset is discarded.
- Latency:
  - Read is 0 cycles (combinational mux).
  - Write-to-array is 1 edge.
  - Write-to-`PMPChangedM` is 1 edge.
- No handshake: one CSR access per cycle; the CSR pipeline guarantees a single writer.

## Structure
- **Shared package `pmppkg`**:
  - `PMPCFG_BASE`=12'h3A0 and `PMPADDR_BASE`=12'h3B0.
  - A-field encodings: OFF=0, TOR=1, NA4=2, NAPOT=3.
  - Config bit positions: R=0, W=1, X=2, A=4:3, L=7.
- **Sub-module `pmpcfglegalize`**: combinational, one per byte lane. It takes the old byte, the new byte and the write enable, and outputs the next byte plus a `changed` bit.
- **Top level**: holds the register arrays, address decode, `pmpaddr` lock logic, read mux and the change-pulse flop.
- **`PMP_ENTRIES`=0**: generates no registers, all reads return 0, `PMPChangedM` is tied to 0.

## Test plan
- **Reset state**: assert `reset` for 1 cycle, then read `pmpcfg0` and `pmpaddr0`. Both read 0; `PMPChangedM`=0.
- **Legalization**: XLEN=64, write `pmpcfg0`=0x0000_0000_0000_00E2.
  - Byte 0 stores 0x80: L set, W cleared because R=0, bits 6:5 cleared.
  - `PMPChangedM`=1 for one cycle.
  - A following write of 0x0F to byte 0 leaves 0x80 and produces no pulse.
- **TOR lock**: write `pmpcfg0`=0x8800, setting entry 1 to L=1 with A=TOR. Then write `pmpaddr0`=0x1234.
  - `pmpaddr0` reads 0.
  - Repeat with entry 1 set to L=1, A=NAPOT: `pmpaddr0` reads 0x1234.
- **Truncation**: PA_BITS=56, write `pmpaddr3`=all ones. The read returns 0x003F_FFFF_FFFF_FFFF.
- **Illegal and unimplemented**: XLEN=64, write `pmpcfg1`.
  - `IllegalPMPAccessM`=1, no state change.
  - With PMP_ENTRIES=16, writing `pmpaddr20` gives no illegal flag and reads 0.
- **Reset mid-write**: assert `CSRMWriteM` to `pmpaddr5`=0xABC in the same cycle as `reset`. Afterwards `pmpaddr5`=0 and `PMPChangedM` stays 0.

Source files
------------

// File: rtl/pmpcsrctrl_pkg.sv
// Shared PMP definitions: CSR base addresses, A-field encodings, config bit
// positions and the config-byte legalization rule.
package pmppkg;

    localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
    localparam logic [11:0] PMPADDR_BASE = 12'h3B0;

    typedef enum logic [1:0] {
        A_OFF   = 2'd0,
        A_TOR   = 2'd1,
        A_NA4   = 2'd2,
        A_NAPOT = 2'd3
    } pmp_a_e;

    localparam int CFG_R    = 0;
    localparam int CFG_W    = 1;
    localparam int CFG_X    = 2;
    localparam int CFG_A_LO = 3;
    localparam int CFG_A_HI = 4;
    localparam int CFG_L    = 7;

    // Reserved bits read as zero and the reserved W-without-R combination is
    // demoted to no access; every A encoding is accepted as written.
    function automatic logic [7:0] legalize_cfg(input logic [7:0] raw);
        logic [7:0] res;
        res      = raw;
        res[6:5] = 2'b00;
        if (res[CFG_W] && !res[CFG_R]) begin
            res[CFG_W] = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/pmpcsrctrl_legalize.sv
// One config byte lane: applies lock filtering and legalization to a write
// and flags whether the stored byte would change.
module pmpcfglegalize
    import pmppkg::*;
(
    input  logic [7:0] old_i,
    input  logic [7:0] new_i,
    input  logic       we_i,
    output logic [7:0] next_o,
    output logic       changed_o
);

    always_comb begin
        next_o = old_i;
        if (we_i && !old_i[CFG_L]) begin
            next_o = legalize_cfg(new_i);
        end
    end

    assign changed_o = (next_o != old_i);

endmodule

// File: rtl/pmpcsrctrl.sv
// PMP CSR controller: owns pmpcfg/pmpaddr state, filters writes through the
// lock rules, serves combinational reads and pulses on any stored change.
module pmpcsrctrl
    import pmppkg::*;
#(
    parameter int PMP_ENTRIES = 16,
    parameter int PA_BITS     = 56,
    parameter int XLEN        = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                CSRMWriteM,
    input  logic [11:0]         CSRAdrM,
    input  logic [XLEN-1:0]     CSRWriteValM,
    output logic [XLEN-1:0]     CSRReadValM,
    output logic                IllegalPMPAccessM,
    output logic [7:0]          PMPCFG_ARRAY_REGW  [(PMP_ENTRIES > 0) ? PMP_ENTRIES : 1],
    output logic [PA_BITS-3:0]  PMPADDR_ARRAY_REGW [(PMP_ENTRIES > 0) ? PMP_ENTRIES : 1],
    output logic                PMPChangedM
);

    localparam int AW        = PA_BITS - 2;
    localparam int CFG_BYTES = XLEN / 8;

    logic        is_cfg;
    logic        is_addr;
    logic [3:0]  cfg_n;
    logic [11:0] addr_off;
    logic [5:0]  addr_idx;

    assign is_cfg   = (CSRAdrM[11:4] == PMPCFG_BASE[11:4]);
    assign cfg_n    = CSRAdrM[3:0];
    assign addr_off = CSRAdrM - PMPADDR_BASE;
    assign is_addr  = (CSRAdrM >= PMPADDR_BASE) && (addr_off[11:6] == 6'd0);
    assign addr_idx = addr_off[5:0];

    // On RV64 the odd pmpcfg registers do not exist; their bytes live in the
    // upper half of the preceding even register.
    assign IllegalPMPAccessM = is_cfg && (XLEN == 64) && cfg_n[0];

    if (PMP_ENTRIES == 0) begin : gen_no_pmp
        assign CSRReadValM           = '0;
        assign PMPChangedM           = 1'b0;
        assign PMPCFG_ARRAY_REGW[0]  = '0;
        assign PMPADDR_ARRAY_REGW[0] = '0;
    end else begin : gen_pmp
        logic [7:0]             cfg_q    [PMP_ENTRIES];
        logic [7:0]             cfg_d    [PMP_ENTRIES];
        logic [AW-1:0]          addr_q   [PMP_ENTRIES];
        logic [AW-1:0]          addr_d   [PMP_ENTRIES];
        logic [XLEN-1:0]        rd_term  [PMP_ENTRIES];
        logic [PMP_ENTRIES-1:0] cfg_chg;
        logic [PMP_ENTRIES-1:0] addr_chg;
        logic [AW-1:0]          addr_wdata;
        logic                   changed_q;

        assign addr_wdata = AW'(CSRWriteValM);

        for (genvar gi = 0; gi < PMP_ENTRIES; gi++) begin : gen_entry
            localparam int CFG_REG  = (gi / CFG_BYTES) * (CFG_BYTES / 4);
            localparam int CFG_BYTE = gi % CFG_BYTES;

            logic cfg_hit;
            logic addr_hit;
            logic tor_lock;
            logic addr_we;

            assign cfg_hit  = is_cfg && !IllegalPMPAccessM && (cfg_n == 4'(CFG_REG));
            assign addr_hit = is_addr && (addr_idx == 6'(gi));

            pmpcfglegalize u_legalize (
                .old_i     (cfg_q[gi]),
                .new_i     (CSRWriteValM[8*CFG_BYTE +: 8]),
                .we_i      (CSRMWriteM && cfg_hit),
                .next_o    (cfg_d[gi]),
                .changed_o (cfg_chg[gi])
            );

            // A locked TOR entry also freezes the base address held by the
            // entry below it.
            if (gi + 1 < PMP_ENTRIES) begin : gen_tor
                assign tor_lock = cfg_q[gi+1][CFG_L] &&
                                  (pmp_a_e'(cfg_q[gi+1][CFG_A_HI:CFG_A_LO]) == A_TOR);
            end else begin : gen_no_tor
                assign tor_lock = 1'b0;
            end

            assign addr_we      = CSRMWriteM && addr_hit && !cfg_q[gi][CFG_L] && !tor_lock;
            assign addr_d[gi]   = addr_we ? addr_wdata : addr_q[gi];
            assign addr_chg[gi] = (addr_d[gi] != addr_q[gi]);

            assign rd_term[gi] = cfg_hit  ? (XLEN'(cfg_q[gi]) << (8 * CFG_BYTE)) :
                                 addr_hit ? XLEN'(addr_q[gi]) : '0;

            assign PMPCFG_ARRAY_REGW[gi]  = cfg_q[gi];
            assign PMPADDR_ARRAY_REGW[gi] = addr_q[gi];
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < PMP_ENTRIES; i++) begin
                    cfg_q[i]  <= '0;
                    addr_q[i] <= '0;
                end
                changed_q <= 1'b0;
            end else begin
                for (int i = 0; i < PMP_ENTRIES; i++) begin
                    cfg_q[i]  <= cfg_d[i];
                    addr_q[i] <= addr_d[i];
                end
                changed_q <= (|cfg_chg) || (|addr_chg);
            end
        end

        always_comb begin
            CSRReadValM = '0;
            for (int i = 0; i < PMP_ENTRIES; i++) begin
                CSRReadValM = CSRReadValM | rd_term[i];
            end
        end

        assign PMPChangedM = changed_q;
    end

endmodule

// File: tb/tb_pmpcsrctrl.sv
// Directed bench for pmpcsrctrl (16 entries, PA_BITS=56, XLEN=64) with
// hand-computed expectations for each CSR access.
module tb_pmpcsrctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        CSRMWriteM;
    logic [11:0] CSRAdrM;
    logic [63:0] CSRWriteValM;
    logic [63:0] CSRReadValM;
    logic        IllegalPMPAccessM;
    logic [7:0]  cfg_arr  [16];
    logic [53:0] addr_arr [16];
    logic        PMPChangedM;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] rv;

    pmpcsrctrl #(.PMP_ENTRIES(16), .PA_BITS(56), .XLEN(64)) dut (
        .clk                (clk),
        .reset              (reset),
        .CSRMWriteM         (CSRMWriteM),
        .CSRAdrM            (CSRAdrM),
        .CSRWriteValM       (CSRWriteValM),
        .CSRReadValM        (CSRReadValM),
        .IllegalPMPAccessM  (IllegalPMPAccessM),
        .PMPCFG_ARRAY_REGW  (cfg_arr),
        .PMPADDR_ARRAY_REGW (addr_arr),
        .PMPChangedM        (PMPChangedM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        CSRMWriteM = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        $display("reset");
    endtask

    // Drive a write on the negedge; returns 1ns after the committing edge.
    task automatic wr(input logic [11:0] adr, input logic [63:0] val);
        @(negedge clk);
        CSRMWriteM   = 1'b1;
        CSRAdrM      = adr;
        CSRWriteValM = val;
        @(posedge clk);
        #1 CSRMWriteM = 1'b0;
        $display("wr  adr=%h data=%h changed=%b", adr, val, PMPChangedM);
    endtask

    task automatic rd(input logic [11:0] adr, output logic [63:0] v);
        CSRAdrM = adr;
        #1 v = CSRReadValM;
        $display("rd  adr=%h data=%h illegal=%b", adr, v, IllegalPMPAccessM);
    endtask

    initial begin
        reset        = 1'b1;
        CSRMWriteM   = 1'b0;
        CSRAdrM      = 12'h000;
        CSRWriteValM = '0;

        // Reset state
        do_reset();
        check("rst_changed", 64'(PMPChangedM), 64'd0);
        rd(12'h3A0, rv); check("rst_cfg0", rv, 64'd0);
        rd(12'h3B0, rv); check("rst_addr0", rv, 64'd0);

        // Legalization: 0xE2 -> 0x80
        wr(12'h3A0, 64'h0000_0000_0000_00E2);
        check("legal_pulse", 64'(PMPChangedM), 64'd1);
        check("legal_arr0", 64'(cfg_arr[0]), 64'h80);
        rd(12'h3A0, rv); check("legal_cfg0", rv, 64'h80);
        @(posedge clk); #1;
        check("legal_pulse_end", 64'(PMPChangedM), 64'd0);
        wr(12'h3A0, 64'h0F);
        check("locked_nopulse", 64'(PMPChangedM), 64'd0);
        rd(12'h3A0, rv); check("locked_cfg0", rv, 64'h80);

        // Same word: byte 0 locked, byte 1 still writable
        wr(12'h3A0, 64'h0303);
        check("mixed_pulse", 64'(PMPChangedM), 64'd1);
        rd(12'h3A0, rv); check("mixed_cfg0", rv, 64'h0380);

        // TOR lock on entry 1 blocks pmpaddr0
        do_reset();
        wr(12'h3A0, 64'h8800);
        rd(12'h3A0, rv); check("tor_cfg0", rv, 64'h8800);
        wr(12'h3B0, 64'h1234);
        check("tor_nopulse", 64'(PMPChangedM), 64'd0);
        rd(12'h3B0, rv); check("tor_addr0", rv, 64'd0);

        // NAPOT lock on entry 1 does not block pmpaddr0
        do_reset();
        wr(12'h3A0, 64'h9800);
        wr(12'h3B0, 64'h1234);
        check("napot_pulse", 64'(PMPChangedM), 64'd1);
        check("napot_arr0", 64'(addr_arr[0]), 64'h1234);
        rd(12'h3B0, rv); check("napot_addr0", rv, 64'h1234);
        wr(12'h3B0, 64'h1234);
        check("same_data_nopulse", 64'(PMPChangedM), 64'd0);

        // Truncation to PA_BITS-2
        wr(12'h3B3, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(12'h3B3, rv); check("trunc_addr3", rv, 64'h003F_FFFF_FFFF_FFFF);

        // Odd pmpcfg on RV64
        rd(12'h3A1, rv);
        check("odd_illegal", 64'(IllegalPMPAccessM), 64'd1);
        check("odd_read", rv, 64'd0);
        wr(12'h3A1, 64'h0F0F_0F0F_0F0F_0F0F);
        check("odd_nopulse", 64'(PMPChangedM), 64'd0);
        rd(12'h3A0, rv); check("odd_cfg0_kept", rv, 64'h9800);
        rd(12'h3A2, rv); check("cfg2_kept", rv, 64'd0);

        // Unimplemented pmpaddr20
        rd(12'h3C4, rv);
        check("unimp_illegal", 64'(IllegalPMPAccessM), 64'd0);
        wr(12'h3C4, 64'h55);
        check("unimp_nopulse", 64'(PMPChangedM), 64'd0);
        rd(12'h3C4, rv); check("unimp_read", rv, 64'd0);

        // Non-PMP CSR
        rd(12'h300, rv);
        check("nonpmp_read", rv, 64'd0);
        check("nonpmp_illegal", 64'(IllegalPMPAccessM), 64'd0);

        // Same-cycle read sees old value; back-to-back changing writes
        @(negedge clk);
        CSRMWriteM = 1'b1; CSRAdrM = 12'h3B5; CSRWriteValM = 64'h777;
        #1 check("same_cycle_old", CSRReadValM, 64'd0);
        @(negedge clk);
        check("b2b_pulse1", 64'(PMPChangedM), 64'd1);
        CSRAdrM = 12'h3B6; CSRWriteValM = 64'h1;
        @(negedge clk);
        check("b2b_pulse2", 64'(PMPChangedM), 64'd1);
        CSRAdrM = 12'h3B7; CSRWriteValM = 64'h2;
        @(negedge clk);
        check("b2b_pulse3", 64'(PMPChangedM), 64'd1);
        CSRMWriteM = 1'b0;
        @(negedge clk);
        check("b2b_pulse_end", 64'(PMPChangedM), 64'd0);
        rd(12'h3B5, rv); check("b2b_addr5", rv, 64'h777);
        rd(12'h3B7, rv); check("b2b_addr7", rv, 64'h2);

        // Write coincident with reset is discarded
        @(negedge clk);
        reset = 1'b1; CSRMWriteM = 1'b1; CSRAdrM = 12'h3B5; CSRWriteValM = 64'hABC;
        @(posedge clk);
        #1 reset = 1'b0; CSRMWriteM = 1'b0;
        check("rstwr_changed", 64'(PMPChangedM), 64'd0);
        rd(12'h3B5, rv); check("rstwr_addr5", rv, 64'd0);
        rd(12'h3A0, rv); check("rstwr_cfg0", rv, 64'd0);
        @(posedge clk); #1;
        check("rstwr_changed_after", 64'(PMPChangedM), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
